// File: rtl/agu_rr_scheduler.sv
// rtl/agu_rr_scheduler.sv - round-robin sharing of one AGU among NUM_REQ requesters
module agu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2,
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 16,
  parameter int TAG_W   = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_base_i,
  input  logic [NUM_REQ*IMM_W-1:0]  req_immd_i,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag_i,
  output logic [DATA_W-1:0]         agu_data1_o,
  output logic [IMM_W-1:0]          agu_immd_o,
  input  logic [DATA_W-1:0]         agu_result_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         out_addr_o,
  output logic [TAG_W-1:0]          out_tag_o,
  output logic [SRC_W-1:0]          out_src_o,
  output logic                      busy_o
);

  logic [DATA_W-1:0] base_arr [NUM_REQ];
  logic [IMM_W-1:0]  immd_arr [NUM_REQ];
  logic [TAG_W-1:0]  tag_arr  [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign base_arr[k] = req_base_i[k*DATA_W +: DATA_W];
    assign immd_arr[k] = req_immd_i[k*IMM_W +: IMM_W];
    assign tag_arr[k]  = req_tag_i[k*TAG_W +: TAG_W];
  end

  logic [SRC_W-1:0] ptr;
  logic [SRC_W-1:0] sel;
  logic [SRC_W-1:0] idx;
  logic [SRC_W-1:0] op_sel;
  logic             found;
  logic             slot_free;
  logic             grant_en;

  // Scan ptr, ptr+1, ... ; SRC_W-bit arithmetic wraps because NUM_REQ is a power of two.
  always_comb begin
    sel   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SRC_W'(i);
      if (!found && req_valid_i[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign slot_free   = ~out_valid_o | out_ready_i;
  assign grant_en    = slot_free & ~flush_i & (|req_valid_i);
  assign req_ready_o = grant_en ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << sel) : '0;
  assign op_sel      = grant_en ? sel : ptr;
  assign agu_data1_o = base_arr[op_sel];
  assign agu_immd_o  = immd_arr[op_sel];
  assign busy_o      = out_valid_o | (|req_valid_i);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_o <= 1'b0;
      out_addr_o  <= '0;
      out_tag_o   <= '0;
      out_src_o   <= '0;
      ptr         <= '0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (grant_en) begin
      out_valid_o <= 1'b1;
      out_addr_o  <= agu_result_i;
      out_tag_o   <= tag_arr[sel];
      out_src_o   <= sel;
      ptr         <= sel + SRC_W'(1);
    end else if (out_ready_i) begin
      // Consumed with nothing to reload: payload fields keep their last values.
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_agu_rr_scheduler.sv
// tb/tb_agu_rr_scheduler.sv - scoreboard bench for agu_rr_scheduler
module tb_agu_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;
  localparam int DATA_W  = 32;
  localparam int IMM_W   = 16;
  localparam int TAG_W   = 6;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
    logic [SRC_W-1:0]  src;
  } entry_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      flush;
  logic [NUM_REQ-1:0]        valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] base_bus;
  logic [NUM_REQ*IMM_W-1:0]  immd_bus;
  logic [NUM_REQ*TAG_W-1:0]  tag_bus;
  logic [DATA_W-1:0]         agu_data1;
  logic [IMM_W-1:0]          agu_immd;
  logic [DATA_W-1:0]         agu_result;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_addr;
  logic [TAG_W-1:0]          out_tag;
  logic [SRC_W-1:0]          out_src;
  logic                      busy;

  logic [DATA_W-1:0] base [NUM_REQ];
  logic [IMM_W-1:0]  immd [NUM_REQ];
  logic [TAG_W-1:0]  tag  [NUM_REQ];

  always_comb begin
    base_bus = '0;
    immd_bus = '0;
    tag_bus  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      base_bus[k*DATA_W +: DATA_W] = base[k];
      immd_bus[k*IMM_W +: IMM_W]   = immd[k];
      tag_bus[k*TAG_W +: TAG_W]    = tag[k];
    end
  end

  // Behavioural AGU standing in for the shared adder.
  assign agu_result = agu_data1 + {{(DATA_W-IMM_W){agu_immd[IMM_W-1]}}, agu_immd};

  agu_rr_scheduler #(.NUM_REQ(NUM_REQ), .SRC_W(SRC_W), .DATA_W(DATA_W), .IMM_W(IMM_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush_i(flush),
    .req_valid_i(valid), .req_ready_o(req_ready),
    .req_base_i(base_bus), .req_immd_i(immd_bus), .req_tag_i(tag_bus),
    .agu_data1_o(agu_data1), .agu_immd_o(agu_immd), .agu_result_i(agu_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_addr_o(out_addr), .out_tag_o(out_tag), .out_src_o(out_src),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  entry_t           q[$];
  entry_t           last;
  logic             m_valid;
  logic [SRC_W-1:0] m_ptr;
  logic             keep_chk;
  logic [NUM_REQ-1:0] g_obs;

  task automatic model_reset();
    q.delete();
    m_valid  = 1'b0;
    m_ptr    = '0;
    keep_chk = 1'b0;
  endtask

  // One clock: check at the falling edge, advance the model, return 1 time unit after the rising edge.
  task automatic step();
    logic               sf, g_en, found, was_valid;
    logic [SRC_W-1:0]   sel, k;
    logic [NUM_REQ-1:0] g_exp;
    entry_t             e, front;
    @(negedge clk);
    sf    = !m_valid || out_ready;
    g_en  = sf && !flush && (|valid);
    g_exp = '0;
    sel   = m_ptr;
    found = 1'b0;
    if (g_en) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = m_ptr + SRC_W'(i);
        if (!found && valid[k]) begin
          sel   = k;
          found = 1'b1;
        end
      end
      g_exp[sel] = 1'b1;
    end
    g_obs = req_ready;
    check("grant", req_ready, g_exp);
    check("out_valid", out_valid, m_valid);
    check("busy", busy, m_valid | (|valid));
    if (m_valid) begin
      if (q.size() == 0) check("sb_underflow", q.size(), 1);
      else begin
        front = q[0];
        check("out_addr", out_addr, front.addr);
        check("out_tag", out_tag, front.tag);
        check("out_src", out_src, front.src);
      end
    end else if (keep_chk) begin
      check("keep_addr", out_addr, last.addr);
      check("keep_tag", out_tag, last.tag);
      check("keep_src", out_src, last.src);
    end
    keep_chk  = 1'b0;
    was_valid = m_valid;
    if (flush) begin
      if (was_valid && q.size() > 0) void'(q.pop_front());
      m_valid = 1'b0;
    end else begin
      if (was_valid && out_ready && q.size() > 0) last = q.pop_front();
      if (g_en) begin
        e.addr = base[sel] + {{(DATA_W-IMM_W){immd[sel][IMM_W-1]}}, immd[sel]};
        e.tag  = tag[sel];
        e.src  = sel;
        q.push_back(e);
        m_valid = 1'b1;
        m_ptr   = sel + SRC_W'(1);
      end else if (was_valid && out_ready) begin
        m_valid  = 1'b0;
        keep_chk = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [DATA_W-1:0] b, input logic [IMM_W-1:0] im, input logic [TAG_W-1:0] t);
    base[k] = b;
    immd[k] = im;
    tag[k]  = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; valid = '0; out_ready = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) set_req(k, DATA_W'(32'h100 * (k + 1)), IMM_W'(k), TAG_W'(k + 8));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_src", out_src, 0);
    reset = 1'b0;

    // Round-robin with all requesters valid and no backpressure.
    valid = '1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rr_order", g_obs, 4'b0001 << (i % 4));
      check("rr_no_bubble", out_valid, 1);
    end
    valid = '0;

    // Single request from requester 2.
    set_req(2, 32'h0000_1000, 16'h0010, 6'd5);
    valid = 4'b0100;
    step();
    check("single_grant", g_obs, 4'b0100);
    check("single_valid", out_valid, 1);
    check("single_addr", out_addr, 32'h0000_1010);
    check("single_tag", out_tag, 5);
    check("single_src", out_src, 2);

    // Negative immediate, then carry wrap-around.
    set_req(0, 32'h0000_0004, 16'hFFF8, 6'd1);
    valid = 4'b0001;
    step();
    check("neg_addr", out_addr, 32'hFFFF_FFFC);
    set_req(1, 32'hFFFF_FFF0, 16'h0020, 6'd2);
    valid = 4'b0010;
    step();
    check("wrap_addr", out_addr, 32'h0000_0010);
    valid = '0;
    step();

    // Backpressure: result pending, requester 1 waits three cycles.
    set_req(0, 32'h0000_2000, 16'h0004, 6'd10);
    valid = 4'b0001; out_ready = 1'b0;
    step();
    set_req(1, 32'h0000_3000, 16'hFFFF, 6'd11);
    valid = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_no_grant", g_obs, 0);
      check("bp_addr_hold", out_addr, 32'h0000_2004);
    end
    out_ready = 1'b1;
    step();
    check("bp_grant", g_obs, 4'b0010);
    check("bp_no_bubble", out_valid, 1);
    check("bp_new_addr", out_addr, 32'h0000_2FFF);
    valid = '0;
    step();

    // Flush with a held result and requester 3 waiting.
    set_req(0, 32'h0000_4000, 16'h0000, 6'd20);
    valid = 4'b0001; out_ready = 1'b0;
    step();
    set_req(3, 32'h0000_5000, 16'h0008, 6'd21);
    valid = 4'b1000; flush = 1'b1;
    step();
    check("flush_no_grant", g_obs, 0);
    check("flush_valid", out_valid, 0);
    flush = 1'b0;
    step();
    check("post_flush_grant", g_obs, 4'b1000);
    out_ready = 1'b1; valid = '0;
    step();

    // Asynchronous reset between edges mid-stream.
    valid = '1;
    step();
    step();
    #3 reset = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    valid = 4'b0011;
    step();
    check("post_rst_grant", g_obs, 4'b0001);
    valid = '0;
    step();

    // Random traffic; operands only change once granted or while not valid.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!valid[k] || g_obs[k]) begin
          valid[k] = 1'($urandom_range(0, 1));
          set_req(k, $urandom, IMM_W'($urandom), TAG_W'($urandom));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      step();
    end
    valid = '0; flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("sb_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/agu_rr_scheduler.md
Name: agu_rr_scheduler

Overview:
- Shares one combinational AGU (base + sign-extended 16-bit immediate) among NUM_REQ address requesters, e.g. SIMD lane load/store ports.
- Arbitrates round-robin, drives the AGU operands, and registers the result with its tag and source ID.
- Presents the result on a valid/ready interface to the memory-request stage.
- Sits between the issue/operand-read stage and the LSU.

Parameters:
- NUM_REQ, 4, number of requesters (power of two, 2..8).
- SRC_W, 2, log2(NUM_REQ).
- DATA_W, 32, base-address and result width.
- IMM_W, 16, immediate width; the AGU sign-extends it to DATA_W.
- TAG_W, 6, opaque per-request tag carried through.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush: drop the held result and block grants this cycle.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  one-hot grant; high only for the accepted requester.
- req_base_i  in  NUM_REQ*DATA_W  packed base operands; requester k at slice [k*DATA_W +: DATA_W].
- req_immd_i  in  NUM_REQ*IMM_W  packed immediates.
- req_tag_i  in  NUM_REQ*TAG_W  packed tags.
- agu_data1_o  out  DATA_W  AGU base operand.
- agu_immd_o  out  IMM_W  AGU immediate operand.
- agu_result_i  in  DATA_W  AGU sum, combinational from the two operands.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- out_addr_o  out  DATA_W  registered effective address.
- out_tag_o  out  TAG_W  tag of the result.
- out_src_o  out  SRC_W  index of the requester that produced the result.
- busy_o  out  1  out_valid_o OR any req_valid_i.

Behaviour:
- Reset values: out_valid_o=0, out_addr_o=0, out_tag_o=0, out_src_o=0, req_ready_o=0, RR pointer=0 (requester 0 has top priority), busy_o follows its equation.
- Output stage is one register, state EMPTY/FULL (FULL ≡ out_valid_o).
- slot_free = !out_valid_o | out_ready_i.
- Grant condition: slot_free & !flush_i & |req_valid_i. When true, exactly one req_ready_o bit is high, combinationally in the same cycle.
- Selection: first valid requester scanning ptr, ptr+1, …, wrapping mod NUM_REQ. After a grant to k, ptr ← (k+1) mod NUM_REQ. With no grant, ptr holds.
- AGU operands: agu_data1_o/agu_immd_o carry the selected requester's operands. With no grant, they carry requester ptr's operands (don't-care, but no X).
- Latency: request accepted at edge N; out_valid_o=1 with out_addr_o=agu_result_i, tag and src captured at edge N+1. Throughput is 1 per cycle while out_ready_i=1.
- Hold: while out_valid_o & !out_ready_i, the output register and all out_* stay stable and no grant is issued.
- Simultaneous consume and accept (FULL, out_ready_i=1, a request valid): the register reloads with the new result and out_valid_o stays 1 (no bubble).
- Consume with no new request: out_valid_o ← 0 next cycle; out_addr_o, out_tag_o and out_src_o keep their last values.
- Flush: out_valid_o ← 0 at the next edge regardless of out_ready_i; no grant that cycle; ptr unchanged.
- Arithmetic: address = base + sext(immd) mod 2^DATA_W. Wrap-around is silent and no overflow flag is produced. The AGU provides this sum; the scheduler does not re-add.
- Requesters must hold valid and operands until granted. Dropping valid before a grant is legal; that request is simply not issued.
- Reset mid-operation: a held result is discarded immediately (asynchronous); ptr returns to 0.

Test Plan:
- Single request: req 2 valid, base=0x0000_1000, immd=0x0010, tag=5, out_ready_i=1 → req_ready_o=0100 in cycle 0; in cycle 1 out_valid_o=1, out_addr_o=0x0000_1010, out_tag_o=5, out_src_o=2.
- Negative immediate and wrap: base=0x0000_0004, immd=0xFFF8 → out_addr_o=0xFFFF_FFFC. Base=0xFFFF_FFF0, immd=0x0020 → out_addr_o=0x0000_0010.
- Round-robin fairness: all 4 requesters valid continuously, out_ready_i=1 → grant order 0,1,2,3,0,1 on consecutive cycles and out_valid_o stays 1 every cycle from cycle 1.
- Backpressure: result pending and out_ready_i=0 for 3 cycles with req 1 valid → req_ready_o=0 and out_* stable for those 3 cycles. out_ready_i=1 in cycle 4 → req 1 granted that cycle and its result appears in cycle 5 with no bubble.
- Flush: out_valid_o=1, flush_i=1 with req 3 valid → no grant; out_valid_o=0 next cycle; req 3 granted the cycle after flush deasserts.
- Async reset: assert reset mid-stream between clock edges → out_valid_o=0 immediately. After release with req 1 and req 0 valid, requester 0 is granted first.
